// File: rtl/pair_select_if.sv
// Signal bundle between the pair-select controller and the cursor, matcher and renderer.
// The master modport is the surrounding game logic and the slave modport is the controller.
interface pair_select_if;
  // click/new_game/m_ms/m_mf are one-cycle pulses sampled on the rising clk edge.
  // They have no back-pressure: a pulse the controller cannot use in its current state is dropped.
  logic        click;
  logic [5:0]  click_pos;
  logic        new_game;
  logic        m_ms;
  logic        m_mf;
  logic [5:0]  m_addr;
  logic [5:0]  disp_addr;
  logic [35:0] m_sel_bus;
  logic [35:0] hidden_bus;
  logic [35:0] sel_bus;
  logic [5:0]  board_addr;
  logic        disp_grant;
  logic [4:0]  score;
  logic [7:0]  misses;
  logic        won;
  logic        busy;

  modport master (
    output click, click_pos, new_game, m_ms, m_mf, m_addr, disp_addr,
    input  m_sel_bus, hidden_bus, sel_bus, board_addr, disp_grant, score, misses, won, busy
  );

  modport slave (
    input  click, click_pos, new_game, m_ms, m_mf, m_addr, disp_addr,
    output m_sel_bus, hidden_bus, sel_bus, board_addr, disp_grant, score, misses, won, busy
  );
endinterface

// File: rtl/pair_select_controller.sv
// Game sequencer: builds a two-card selection from clicks, presents it to the matcher,
// applies the result, shares the board read port, and keeps score, misses and the win flag.
module pair_select_controller #(
  parameter logic [31:0] MISS_HOLD     = 32'd50_000_000,
  parameter logic [31:0] CHECK_TIMEOUT = 32'd255
) (
  input  logic         clk,
  input  logic         rst,
  pair_select_if.slave bus,
  output logic [2:0]   o_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ONE   = 3'd1,
    S_CHECK = 3'd2,
    S_MISS  = 3'd3,
    S_WON   = 3'd4
  } state_t;

  state_t      r_state, w_state_n;
  logic [35:0] r_sel, w_sel_n;
  logic [35:0] r_m_sel, w_m_sel_n;
  logic [35:0] r_hidden, w_hidden_n;
  logic [4:0]  r_score, w_score_n;
  logic [7:0]  r_misses, w_misses_n;
  logic        r_won, w_won_n;
  logic        r_busy, w_busy_n;
  logic [31:0] r_timer, w_timer_n;

  logic [63:0] w_hid64;
  logic [35:0] w_pos_mask;
  logic [35:0] w_sel_rev;
  logic [31:0] w_timer_inc;
  logic        w_click_ok;

  // Positions 36..63 read as "hidden", so one lookup rejects both out-of-range and removed cards.
  always_comb begin
    w_hid64     = {28'hFFF_FFFF, r_hidden};
    w_click_ok  = bus.click && !w_hid64[bus.click_pos];
    w_timer_inc = r_timer + 32'd1;
    w_pos_mask  = '0;
    w_sel_rev   = '0;
    for (int i = 0; i < 36; i++) begin
      w_pos_mask[35-i] = (bus.click_pos == i[5:0]);
      w_sel_rev[i]     = r_sel[35-i];
    end
  end

  always_comb begin
    w_state_n  = r_state;
    w_sel_n    = r_sel;
    w_hidden_n = r_hidden;
    w_score_n  = r_score;
    w_misses_n = r_misses;
    w_won_n    = r_won;
    w_timer_n  = r_timer;
    if (bus.new_game) begin
      w_state_n  = S_IDLE;
      w_sel_n    = '0;
      w_hidden_n = '0;
      w_score_n  = '0;
      w_misses_n = '0;
      w_won_n    = 1'b0;
      w_timer_n  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_click_ok) begin
            w_sel_n   = r_sel | w_pos_mask;
            w_state_n = S_ONE;
          end
        end
        S_ONE: begin
          if (w_click_ok) begin
            if ((r_sel & w_pos_mask) != '0) begin
              w_sel_n   = r_sel & ~w_pos_mask;
              w_state_n = S_IDLE;
            end else begin
              w_sel_n   = r_sel | w_pos_mask;
              w_timer_n = '0;
              w_state_n = S_CHECK;
            end
          end
        end
        S_CHECK: begin
          // Success outranks failure when the matcher raises both in one cycle.
          if (bus.m_ms) begin
            w_hidden_n = r_hidden | w_sel_rev;
            w_sel_n    = '0;
            w_score_n  = r_score + 5'd1;
            if (r_score == 5'd17) begin
              w_won_n   = 1'b1;
              w_state_n = S_WON;
            end else begin
              w_state_n = S_IDLE;
            end
          end else if (bus.m_mf || (w_timer_inc == CHECK_TIMEOUT)) begin
            w_misses_n = (r_misses == 8'hFF) ? r_misses : r_misses + 8'd1;
            w_timer_n  = '0;
            w_state_n  = S_MISS;
          end else begin
            w_timer_n = w_timer_inc;
          end
        end
        S_MISS: begin
          if (w_timer_inc == MISS_HOLD) begin
            w_sel_n   = '0;
            w_timer_n = '0;
            w_state_n = S_IDLE;
          end else begin
            w_timer_n = w_timer_inc;
          end
        end
        S_WON:   w_state_n = S_WON;
        default: w_state_n = S_IDLE;
      endcase
    end
    // Matcher view is registered alongside the state so it is non-zero only while in CHECK.
    w_m_sel_n = (w_state_n == S_CHECK) ? w_sel_n : '0;
    w_busy_n  = (w_state_n == S_CHECK) || (w_state_n == S_MISS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_m_sel  <= '0;
      r_hidden <= '0;
      r_score  <= '0;
      r_misses <= '0;
      r_won    <= 1'b0;
      r_busy   <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_n;
      r_sel    <= w_sel_n;
      r_m_sel  <= w_m_sel_n;
      r_hidden <= w_hidden_n;
      r_score  <= w_score_n;
      r_misses <= w_misses_n;
      r_won    <= w_won_n;
      r_busy   <= w_busy_n;
      r_timer  <= w_timer_n;
    end
  end

  assign bus.board_addr = (r_state == S_CHECK) ? bus.m_addr : bus.disp_addr;
  assign bus.disp_grant = (r_state != S_CHECK);
  assign bus.sel_bus    = r_sel;
  assign bus.m_sel_bus  = r_m_sel;
  assign bus.hidden_bus = r_hidden;
  assign bus.score      = r_score;
  assign bus.misses     = r_misses;
  assign bus.won        = r_won;
  assign bus.busy       = r_busy;
  assign o_state        = r_state;

endmodule

// File: tb/tb_pair_select_controller.sv
// Directed bench for pair_select_controller: every registered output change is matched,
// in order and by cycle, against an expected snapshot queued when the stimulus was issued.
module tb_pair_select_controller;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ONE   = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_MISS  = 3'd3;
  localparam logic [2:0] ST_WON   = 3'd4;

  typedef struct packed {
    logic [31:0] cyc;
    logic [2:0]  st;
    logic [35:0] sel;
    logic [35:0] msel;
    logic [35:0] hid;
    logic [4:0]  score;
    logic [7:0]  misses;
    logic        won;
    logic        busy;
  } obs_t;

  localparam int W = $bits(obs_t);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  o_state;
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;
  logic        mon_en = 1'b0;
  logic [W-1:0] exp_q[$];
  obs_t        e;
  obs_t        m_cur, m_want, m_prev;

  pair_select_if bus ();

  pair_select_controller #(
    .MISS_HOLD     (32'd5),
    .CHECK_TIMEOUT (32'd10)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .o_state (o_state)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [35:0] sbit(input int k);
    logic [35:0] one;
    one = 36'd1;
    return one << (35 - k);
  endfunction

  function automatic logic [35:0] hbit(input int k);
    logic [35:0] one;
    one = 36'd1;
    return one << k;
  endfunction

  function automatic obs_t snap();
    obs_t s;
    s.cyc    = '0;
    s.st     = o_state;
    s.sel    = bus.sel_bus;
    s.msel   = bus.m_sel_bus;
    s.hid    = bus.hidden_bus;
    s.score  = bus.score;
    s.misses = bus.misses;
    s.won    = bus.won;
    s.busy   = bus.busy;
    return s;
  endfunction

  // Driver tasks
  task automatic apply(input logic c, input logic [5:0] p, input logic ms, input logic mf,
                       input logic ng);
    @(negedge clk);
    bus.click     = c;
    bus.click_pos = p;
    bus.m_ms      = ms;
    bus.m_mf      = mf;
    bus.new_game  = ng;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic click_at(input int k);
    apply(1'b1, k[5:0], 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_next();
    e.cyc = cyc + 1;
    exp_q.push_back(e);
  endtask

  task automatic push_at(input int unsigned at);
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    m_cur = snap();
    if (mon_en && (m_cur !== m_prev)) begin
      n_vec++;
      m_cur.cyc = cyc;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change: cyc=%0d st=%0d sel=%h msel=%h hid=%h score=%0d misses=%0d won=%b busy=%b, expected no change",
                 m_cur.cyc, m_cur.st, m_cur.sel, m_cur.msel, m_cur.hid, m_cur.score,
                 m_cur.misses, m_cur.won, m_cur.busy);
      end else begin
        m_want = exp_q.pop_front();
        if (m_cur !== m_want) begin
          n_bad++;
          $display("FAIL output_change: got cyc=%0d st=%0d sel=%h msel=%h hid=%h score=%0d misses=%0d won=%b busy=%b, expected cyc=%0d st=%0d sel=%h msel=%h hid=%h score=%0d misses=%0d won=%b busy=%b",
                   m_cur.cyc, m_cur.st, m_cur.sel, m_cur.msel, m_cur.hid, m_cur.score,
                   m_cur.misses, m_cur.won, m_cur.busy,
                   m_want.cyc, m_want.st, m_want.sel, m_want.msel, m_want.hid, m_want.score,
                   m_want.misses, m_want.won, m_want.busy);
        end
      end
    end
    m_prev = snap();
  end

  int unsigned t0;

  initial begin
    bus.click     = 1'b0;
    bus.click_pos = 6'd0;
    bus.new_game  = 1'b0;
    bus.m_ms      = 1'b0;
    bus.m_mf      = 1'b0;
    bus.m_addr    = 6'd21;
    bus.disp_addr = 6'd42;
    e = '0;

    // Reset values
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 64'(o_state), 64'(ST_IDLE));
    check("rst_sel", 64'(bus.sel_bus), 64'd0);
    check("rst_msel", 64'(bus.m_sel_bus), 64'd0);
    check("rst_hidden", 64'(bus.hidden_bus), 64'd0);
    check("rst_score", 64'(bus.score), 64'd0);
    check("rst_misses", 64'(bus.misses), 64'd0);
    check("rst_won_busy", 64'({bus.won, bus.busy}), 64'd0);
    check("rst_grant", 64'(bus.disp_grant), 64'd1);
    check("rst_board_addr", 64'(bus.board_addr), 64'd42);
    mon_en = 1'b1;

    // Match of cards 0 and 7
    click_at(0);
    e.st = ST_ONE; e.sel = sbit(0); push_next();
    click_at(7);
    e.st = ST_CHECK; e.sel = sbit(0) | sbit(7); e.msel = e.sel; e.busy = 1'b1; push_next();
    idle(1);
    check("check_grant", 64'(bus.disp_grant), 64'd0);
    check("check_board_addr", 64'(bus.board_addr), 64'd21);
    idle(2);
    apply(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
    e.st = ST_IDLE; e.sel = '0; e.msel = '0; e.hid = 36'h0_0000_0081; e.score = 5'd1;
    e.busy = 1'b0; push_next();
    idle(1);
    check("idle_grant", 64'(bus.disp_grant), 64'd1);
    check("idle_board_addr", 64'(bus.board_addr), 64'd42);

    // Select and deselect the same card
    click_at(3);
    e.st = ST_ONE; e.sel = sbit(3); push_next();
    click_at(3);
    e.st = ST_IDLE; e.sel = '0; push_next();
    idle(1);

    // Mismatch: selection held for MISS_HOLD cycles, clicks ignored meanwhile
    click_at(1);
    e.st = ST_ONE; e.sel = sbit(1); push_next();
    click_at(2);
    e.st = ST_CHECK; e.sel = sbit(1) | sbit(2); e.msel = e.sel; e.busy = 1'b1; push_next();
    apply(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
    t0 = cyc + 1;
    e.st = ST_MISS; e.msel = '0; e.misses = 8'd1; push_at(t0);
    click_at(5);
    click_at(6);
    e.st = ST_IDLE; e.sel = '0; e.busy = 1'b0; push_at(t0 + 5);
    idle(5);

    // Hidden card, out-of-range position and stray matcher pulses are all ignored
    click_at(7);
    click_at(40);
    apply(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
    click_at(4);
    e.st = ST_ONE; e.sel = sbit(4); push_next();
    click_at(0);
    click_at(63);
    click_at(4);
    e.st = ST_IDLE; e.sel = '0; push_next();
    idle(1);

    // Simultaneous success and failure counts as success
    click_at(8);
    e.st = ST_ONE; e.sel = sbit(8); push_next();
    click_at(9);
    e.st = ST_CHECK; e.sel = sbit(8) | sbit(9); e.msel = e.sel; e.busy = 1'b1; push_next();
    apply(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
    e.st = ST_IDLE; e.sel = '0; e.msel = '0; e.busy = 1'b0; e.score = 5'd2;
    e.hid = e.hid | hbit(8) | hbit(9); push_next();
    idle(1);

    // Asynchronous reset in the middle of CHECK
    click_at(10);
    e.st = ST_ONE; e.sel = sbit(10); push_next();
    click_at(11);
    e.st = ST_CHECK; e.sel = sbit(10) | sbit(11); e.msel = e.sel; e.busy = 1'b1; push_next();
    idle(1);
    @(negedge clk);
    #2 rst = 1'b1;
    e = '0; push_next();
    #1;
    check("async_rst_msel", 64'(bus.m_sel_bus), 64'd0);
    check("async_rst_sel", 64'(bus.sel_bus), 64'd0);
    check("async_rst_hidden_score", 64'({bus.hidden_bus, bus.score}), 64'd0);
    check("async_rst_grant", 64'(bus.disp_grant), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;

    // Matcher never answers: forced failure after CHECK_TIMEOUT cycles
    click_at(12);
    e.st = ST_ONE; e.sel = sbit(12); push_next();
    click_at(13);
    t0 = cyc + 1;
    e.st = ST_CHECK; e.sel = sbit(12) | sbit(13); e.msel = e.sel; e.busy = 1'b1; push_at(t0);
    e.st = ST_MISS; e.msel = '0; e.misses = 8'd1; push_at(t0 + 10);
    e.st = ST_IDLE; e.sel = '0; e.busy = 1'b0; push_at(t0 + 15);
    idle(17);

    // Clear the board with 18 matches
    for (int k = 0; k < 18; k++) begin
      click_at(2 * k);
      e.st = ST_ONE; e.sel = sbit(2 * k); push_next();
      click_at(2 * k + 1);
      e.st = ST_CHECK; e.sel = sbit(2 * k) | sbit(2 * k + 1); e.msel = e.sel; e.busy = 1'b1;
      push_next();
      apply(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
      e.sel = '0; e.msel = '0; e.busy = 1'b0; e.score = 5'(k + 1);
      e.hid = e.hid | hbit(2 * k) | hbit(2 * k + 1);
      if (k == 17) begin
        e.st = ST_WON; e.won = 1'b1;
      end else begin
        e.st = ST_IDLE;
      end
      push_next();
    end
    idle(1);
    check("won_hidden_all", 64'(bus.hidden_bus), 64'h0000_000F_FFFF_FFFF);
    check("won_score", 64'(bus.score), 64'd18);

    // WON ignores clicks and matcher pulses
    click_at(0);
    click_at(35);
    apply(1'b0, 6'd0, 1'b1, 1'b1, 1'b0);
    idle(2);

    // new_game wins over a same-cycle click
    apply(1'b1, 6'd3, 1'b0, 1'b0, 1'b1);
    e = '0; push_next();
    idle(3);
    check("newgame_grant", 64'(bus.disp_grant), 64'd1);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
